// File: rtl/culsans_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumPorts requesters, with an optional
// bounded lock. Define CULSANS_SRAM_ARB_RDATA_REG_EN to register read data (2-cycle response).
//
// state  | meaning
// IDLE   | round-robin arbitration among all requesters
// LOCKED | only the lock owner may be granted; bounded by MaxLockCycles

module culsans_sram_arbiter #(
    parameter int unsigned NumPorts      = 4,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned MaxLockCycles = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumPorts-1:0]             req_i,
    input  logic [NumPorts-1:0]             we_i,
    input  logic [NumPorts-1:0]             lock_i,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i,
    input  logic [NumPorts*DataWidth/8-1:0] be_i,
    output logic [NumPorts-1:0]             gnt_o,
    output logic [NumPorts-1:0]             rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            sram_req_o,
    output logic                            sram_we_o,
    output logic [AddrWidth-1:0]            sram_addr_o,
    output logic [DataWidth-1:0]            sram_wdata_o,
    output logic [DataWidth/8-1:0]          sram_be_o,
    input  logic [DataWidth-1:0]            sram_rdata_i,
    output logic                            locked_o
);

    localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned BeW  = DataWidth / 8;
    localparam int unsigned CntW = $clog2(MaxLockCycles + 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [NumPorts-1:0] gnt;
    logic [IdxW-1:0]     gnt_idx;
    logic [IdxW-1:0]     arb_cand;
    logic                arb_found;
    int                  arb_sum;

    // Explicit wrap keeps non-power-of-two port counts in range.
    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] k);
        if (k == IdxW'(NumPorts - 1)) return '0;
        return k + IdxW'(1);
    endfunction

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        arb_cand  = '0;
        arb_found = 1'b0;
        arb_sum   = 0;
        if (!rst_i) begin
            if (state_q == LOCKED) begin
                if (req_i[owner_q]) begin
                    gnt_idx = owner_q;
                    gnt[owner_q] = 1'b1;
                end
            end else begin
                for (int i = 0; i < int'(NumPorts); i++) begin
                    arb_sum = int'(ptr_q) + i;
                    if (arb_sum >= int'(NumPorts)) arb_sum = arb_sum - int'(NumPorts);
                    arb_cand = IdxW'(arb_sum);
                    if (!arb_found && req_i[arb_cand]) begin
                        arb_found = 1'b1;
                        gnt_idx   = arb_cand;
                    end
                end
                if (arb_found) gnt[gnt_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            if (gnt[i]) begin
                sram_we_o    = sram_we_o | we_i[i];
                sram_addr_o  = sram_addr_o | addr_i[i*AddrWidth +: AddrWidth];
                sram_wdata_o = sram_wdata_o | wdata_i[i*DataWidth +: DataWidth];
                sram_be_o    = sram_be_o | be_i[i*BeW +: BeW];
            end
        end
    end

    assign gnt_o      = gnt;
    assign sram_req_o = |gnt;
    assign locked_o   = (state_q == LOCKED);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CntW'(1);
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    ptr_d = next_idx(gnt_idx);
                    if (lock_i[gnt_idx] && (MaxLockCycles > 1)) begin
                        state_d = LOCKED;
                        owner_d = gnt_idx;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            LOCKED: begin
                // The counter runs whether or not the owner is using its slot.
                if ((req_i[owner_q] && !lock_i[owner_q]) ||
                    (cnt_inc >= CntW'(MaxLockCycles))) begin
                    state_d = IDLE;
                    ptr_d   = next_idx(owner_q);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CULSANS_SRAM_ARB_RDATA_REG_EN
    logic [NumPorts-1:0]  rsp0_q, rsp1_q;
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp0_q <= '0;
            rsp1_q <= '0;
        end else begin
            rsp0_q <= gnt;
            rsp1_q <= rsp0_q;
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= sram_rdata_i;
    end

    assign rvalid_o = rsp1_q;
    assign rdata_o  = rdata_q;
`else
    logic [NumPorts-1:0] rsp_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rsp_q <= '0;
        else       rsp_q <= gnt;
    end

    assign rvalid_o = rsp_q;
    assign rdata_o  = sram_rdata_i;
`endif

endmodule

// File: tb/tb_culsans_sram_arbiter.sv
// Directed bench for culsans_sram_arbiter: vector table for round-robin/lock,
// hand sequences for forced release, data path, reset mid-operation and NumPorts=3.

module tb_culsans_sram_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = 8;
`ifdef CULSANS_SRAM_ARB_RDATA_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NP-1:0]     req, we, lock;
    logic [AW-1:0]     addr  [NP];
    logic [DW-1:0]     wdata [NP];
    logic [BW-1:0]     be    [NP];
    logic [NP*AW-1:0]  addr_bus;
    logic [NP*DW-1:0]  wdata_bus;
    logic [NP*BW-1:0]  be_bus;
    logic [NP-1:0]     gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic              sram_req, sram_we, locked;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata;
    logic [BW-1:0]     sram_be;
    logic [DW-1:0]     sram_rdata = '0;
    logic [DW-1:0]     mem [256] = '{default: '0};

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            addr_bus[p*AW +: AW]  = addr[p];
            wdata_bus[p*DW +: DW] = wdata[p];
            be_bus[p*BW +: BW]    = be[p];
        end
    end

    culsans_sram_arbiter dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .lock_i(lock),
        .addr_i(addr_bus), .wdata_i(wdata_bus), .be_i(be_bus),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata),
        .locked_o(locked)
    );

    // SRAM model: read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr[7:0]];
            end
        end
    end

    // Three-port instance for the non-power-of-two wrap.
    logic [2:0]      req3, gnt3, rvalid3;
    logic [3*AW-1:0] addr3 = {32'h3, 32'h2, 32'h1};
    logic [3*DW-1:0] wdata3 = '0;
    logic [3*BW-1:0] be3 = '1;
    logic [DW-1:0]   rdata3, sram_wdata3;
    logic [AW-1:0]   sram_addr3;
    logic [BW-1:0]   sram_be3;
    logic            sram_req3, sram_we3, locked3;

    culsans_sram_arbiter #(.NumPorts(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .we_i(3'b000), .lock_i(3'b000),
        .addr_i(addr3), .wdata_i(wdata3), .be_i(be3),
        .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3),
        .sram_req_o(sram_req3), .sram_we_o(sram_we3), .sram_addr_o(sram_addr3),
        .sram_wdata_o(sram_wdata3), .sram_be_o(sram_be3), .sram_rdata_i(64'h0),
        .locked_o(locked3)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] we;
        logic [3:0] lock;
        logic [3:0] gnt;
        logic       lk;
    } vec_t;

    vec_t       tbl [19];
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] hist [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle at posedge+1, check mid-cycle, leave at next posedge+1.
    task automatic step(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l,
                        input logic [3:0] eg, input logic elk,
                        input logic crd, input logic [63:0] erd);
        logic [AW-1:0] ea;
        logic          ewe;
        req = r; we = w; lock = l;
        @(negedge clk);
        chk("gnt", 64'(gnt), 64'(eg));
        chk("rvalid", 64'(rvalid), 64'(hist[LAT-1]));
        chk("locked", 64'(locked), 64'(elk));
        chk("sram_req", 64'(sram_req), 64'(|eg));
        if (eg != 4'b0000) begin
            ea = '0; ewe = 1'b0;
            for (int p = 0; p < NP; p++)
                if (eg[p]) begin ea = addr[p]; ewe = w[p]; end
            chk("sram_addr", 64'(sram_addr), 64'(ea));
            chk("sram_we", 64'(sram_we), 64'(ewe));
        end
        if (crd) chk("rdata", rdata, erd);
        hist[1] = hist[0];
        hist[0] = eg;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[5]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        tbl[6]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[7]  = '{4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[11] = '{4'b1011, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[12] = '{4'b0011, 4'b0001, 4'b0000, 4'b0001, 1'b0};
        tbl[13] = '{4'b1011, 4'b0000, 4'b0010, 4'b0010, 1'b0};
        tbl[14] = '{4'b1011, 4'b0000, 4'b0010, 4'b0010, 1'b1};
        tbl[15] = '{4'b1011, 4'b0000, 4'b0000, 4'b0010, 1'b1};
        tbl[16] = '{4'b1001, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[17] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        rst = 1'b1; req = '0; we = '0; lock = '0; req3 = '0;
        for (int p = 0; p < NP; p++) begin
            addr[p]  = 32'h10 + 32'(p);
            wdata[p] = {32'hA5A5_0000 + 32'(p), 32'h0};
            be[p]    = 8'hFF;
        end
        hist[0] = '0; hist[1] = '0;

        repeat (2) @(posedge clk);
        #1 req = 4'hF;
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_sram_req", 64'(sram_req), 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_locked", 64'(locked), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; req = '0;

        for (int i = 0; i < 19; i++)
            step(tbl[i].req, tbl[i].we, tbl[i].lock, tbl[i].gnt, tbl[i].lk, 1'b0, 64'h0);

        // Port 0 holds the lock; owner idles in cycle 5; release after cycle 16.
        for (int c = 1; c <= 17; c++) begin
            logic [3:0] r, eg;
            r  = (c == 1) ? 4'b0001 : (c == 5) ? 4'b0010 : 4'b0011;
            eg = (c == 17) ? 4'b0010 : (c == 5) ? 4'b0000 : 4'b0001;
            step(r, 4'b0000, 4'b0001, eg, (c >= 2 && c <= 16), 1'b0, 64'h0);
        end

        // Data path: full write, read back, partial-byte overwrite, read back.
        addr[1] = 32'h40; wdata[1] = 64'hDEADBEEF_CAFEF00D; be[1] = 8'hFF;
        addr[2] = 32'h40;
        addr[3] = 32'h40; wdata[3] = 64'h11223344_55667788; be[3] = 8'h0F;
        addr[0] = 32'h40;
        step(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0, 64'h0);
        step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 64'h0);
        for (int k = 1; k <= LAT; k++)
            step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, (k == LAT), 64'hDEADBEEF_CAFEF00D);
        step(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0, 64'h0);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 64'h0);
        for (int k = 1; k <= LAT; k++)
            step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, (k == LAT), 64'hDEADBEEF_55667788);

        // Locked read grant, then reset while its response is pending.
        step(4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rvalid", 64'(rvalid), 64'h0);
        chk("midrst_locked", 64'(locked), 64'h0);
        chk("midrst_gnt", 64'(gnt), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        hist[0] = '0; hist[1] = '0;
        step(4'b1100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 64'h0);
        for (int k = 0; k < 2; k++)
            step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 64'h0);

        // Three ports: 1 and 2 alternate, pointer wraps from 2 to 0.
        req3 = 3'b110;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("np3_gnt", 64'(gnt3), (k % 2 == 0) ? 64'h2 : 64'h4);
            chk("np3_addr", 64'(sram_addr3), (k % 2 == 0) ? 64'h2 : 64'h3);
            @(posedge clk); #1;
        end
        req3 = 3'b000;
        @(negedge clk);
        chk("np3_locked", 64'(locked3), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/culsans_sram_arbiter.md
Name: culsans_sram_arbiter

Overview:
- Shares the single-port simulation SRAM of the culsans top-level between NumPorts requesters (core data ports, DMA/preload agent).
- Round-robin grant per cycle; fixed-latency read responses routed back to the originating port.
- Optional lock lets one requester hold the SRAM for atomic read-modify-write sequences.
- Sits between the interconnect/requester ports and the SRAM cut.

Parameters:
- NumPorts, 4, number of requesters (2..16)
- AddrWidth, 32, word address width
- DataWidth, 64, data width; byte-enable width is DataWidth/8
- MaxLockCycles, 16, upper bound on a continuous lock before forced release

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  NumPorts  per-port request
- we_i  in  NumPorts  per-port write enable
- lock_i  in  NumPorts  per-port lock request, sampled with a granted req
- addr_i  in  NumPorts*AddrWidth  per-port address
- wdata_i  in  NumPorts*DataWidth  per-port write data
- be_i  in  NumPorts*DataWidth/8  per-port byte enables
- gnt_o  out  NumPorts  one-hot grant, combinational
- rvalid_o  out  NumPorts  per-port response valid
- rdata_o  out  DataWidth  read data, shared and qualified by rvalid_o
- sram_req_o  out  1  SRAM access strobe
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  AddrWidth  SRAM address
- sram_wdata_o  out  DataWidth  SRAM write data
- sram_be_o  out  DataWidth/8  SRAM byte enables
- sram_rdata_i  in  DataWidth  SRAM read data, valid 1 cycle after sram_req_o
- locked_o  out  1  lock currently held

Behaviour:
- Reset: RR pointer=0, FSM=IDLE, lock owner=0, lock counter=0, response pipeline empty. rvalid_o=0, locked_o=0. gnt_o/sram_req_o=0 while rst_i is high.
- Request rules:
  - Requester holds req/we/addr/wdata/be stable until gnt.
  - gnt_o[i] and sram_req_o are combinational in the same cycle; sram_* fields are muxed from the granted port.
  - At most one grant per cycle.
- IDLE arbitration:
  - Grant the first requesting port at index >= pointer, wrapping modulo NumPorts.
  - After a grant to port k, pointer <= (k+1) mod NumPorts; pointer unchanged when no grant.
- Lock entry: IDLE -> LOCKED when the granted port k has lock_i[k]=1. Owner <= k, counter <= 1, locked_o=1 from the next cycle.
- LOCKED state:
  - Only the owner is eligible; other requests wait, with no grant and no pointer change.
  - Each owner grant with lock_i=1 increments the counter.
  - Owner grant with lock_i=0 completes the access and returns to IDLE; pointer <= owner+1.
  - Owner not requesting: remains LOCKED and the counter still increments each cycle.
  - Counter reaching MaxLockCycles forces IDLE next cycle regardless of lock_i; pointer <= owner+1.
- Response path:
  - A granted read (we=0) pushes the port index.
  - rvalid_o[port]=1 exactly 1 cycle later, with rdata_o=sram_rdata_i.
  - Writes produce rvalid_o 1 cycle later with rdata_o undefined (ack).
  - Back-to-back grants give back-to-back rvalid pulses, one per cycle.
- Simultaneous events: a response for port i and a new grant to port i in the same cycle are both legal.
- Reset mid-operation: a pending rvalid is dropped, the lock is released, and the pointer returns to 0.
- Width rule: NumPorts not a power of two → pointer wraps explicitly at NumPorts-1, with no out-of-range index.

Optional Feature:
- Macro CULSANS_SRAM_ARB_RDATA_REG_EN.
- Defined:
  - sram_rdata_i is registered before rdata_o; read/write response latency becomes 2 cycles.
  - Response pipeline is 2 entries deep; full throughput is kept (one grant per cycle).
- Undefined: latency is 1 cycle, with no extra register.

Test Plan:
- Ports 0..3 all request continuously, no lock, 8 cycles -> grants 0,1,2,3,0,1,2,3 and pointer cycles back to 0; each read rvalid 1 cycle after grant (2 with the macro).
- Port 2 reads addr 0x40 after port 1 writes 0xDEADBEEF_CAFEF00D with be=0xFF to 0x40 -> port 2 rdata_o=0xDEADBEEF_CAFEF00D, rvalid only on bit 2.
- Port 1 locks for 3 accesses while ports 0 and 3 request -> only port 1 granted 3 cycles, locked_o high; then grant goes to port 3, then 0.
- Port 0 holds lock_i=1 with MaxLockCycles=16 -> forced release after 16 cycles; port 1 granted on cycle 17.
- rst_i asserted one cycle after a read grant -> no rvalid_o, locked_o=0; first grant after release goes to the lowest requesting port.
- NumPorts=3, ports 1 and 2 requesting -> alternating 1,2,1,2 with no grant to a non-existent index.
